// File: rtl/dw_out_serializer_pkg.sv
// Shared constants and helpers for the decoded-word output serializer.
// Holds the reset polarity, a clog2 helper and the beat-count macro.
package dw_out_serializer_pkg;

   localparam logic RESET_VAL = 1'b1;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

`ifndef DW_NB
`define DW_NB(k, n) (((k) + (n) - 1) / (n))
`endif

// File: rtl/dw_out_serializer_if.sv
// Word-in / beat-out handshake bundle of the output serializer.
// The slave side is the serializer, the master side is its environment.
interface dw_out_if #(
   parameter int K     = 32,
   parameter int N_OUT = 4
);
   logic [K-1:0]     dw_in;
   logic             dw_valid;
   logic             dw_ready;
   logic [N_OUT-1:0] data_out;
   logic             data_valid_out;
   logic             first_data_out;
   logic             last_data_out;
   logic             sink_ready;

   modport slave (
      input  dw_in, dw_valid, sink_ready,
      output dw_ready, data_out, data_valid_out,
      output first_data_out, last_data_out
   );

   modport master (
      output dw_in, dw_valid, sink_ready,
      input  dw_ready, data_out, data_valid_out,
      input  first_data_out, last_data_out
   );
endinterface

// File: rtl/dw_out_serializer_word_buffer.sv
// Active/pending word pair with full flags and routing of new words.
// a_load flags that a fresh word entered A, so beat counting restarts.
module dw_word_buffer
   import dw_out_serializer_pkg::*;
#(
   parameter int K = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [K-1:0] in_word,
   input  logic         finish,
   output logic         in_ready,
   output logic [K-1:0] a_word,
   output logic         a_full,
   output logic         a_load
);

   logic [K-1:0] a_q, a_d;
   logic [K-1:0] p_q, p_d;
   logic         a_full_q, a_full_d;
   logic         p_full_q, p_full_d;
   logic         rdy_q, rdy_d;
   logic         accept;

   assign in_ready = rdy_q;
   assign a_word   = a_q;
   assign a_full   = a_full_q;

   // Route a finished word out and an accepted word into A or P.
   always_comb begin
      accept   = in_valid & rdy_q;
      a_d      = a_q;
      a_full_d = a_full_q;
      p_d      = p_q;
      p_full_d = p_full_q;
      a_load   = 1'b0;
      if (finish) begin
         if (p_full_q) begin
            a_d      = p_q;
            p_full_d = 1'b0;
            a_load   = 1'b1;
         end else begin
            a_full_d = 1'b0;
         end
      end
      if (accept) begin
         if (!a_full_q || finish) begin
            a_d      = in_word;
            a_full_d = 1'b1;
            a_load   = 1'b1;
         end else begin
            p_d      = in_word;
            p_full_d = 1'b1;
         end
      end
      rdy_d = !p_full_d;
   end

   // Word storage; ready stays low during reset and rises after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RESET_VAL) begin
         a_q      <= '0;
         p_q      <= '0;
         a_full_q <= 1'b0;
         p_full_q <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         p_q      <= p_d;
         a_full_q <= a_full_d;
         p_full_q <= p_full_d;
         rdy_q    <= rdy_d;
      end
   end

endmodule

// File: rtl/dw_out_serializer.sv
// Streams each decoded information word out in N_OUT-bit beats,
// lowest segment first, zero-padding the top of the final beat.
module dw_out_serializer
   import dw_out_serializer_pkg::*;
#(
   parameter int N_V   = 44,
   parameter int N_C   = 12,
   parameter int N_OUT = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   dw_out_if.slave          bus,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int K      = N_V - N_C;
   localparam int NB     = `DW_NB(K, N_OUT);
   localparam int BEAT_W = (clog2(NB) < 1) ? 1 : clog2(NB);
   localparam int EXT_W  = NB * N_OUT;

   logic [K-1:0]      a_word;
   logic              a_full;
   logic              a_load;
   logic              in_ready;
   logic              xfer;
   logic              finish;
   logic              is_first;
   logic              is_last;
   logic [EXT_W-1:0]  a_ext;
   logic [N_OUT-1:0]  beat_data;
   logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

   dw_word_buffer #(.K(K)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .in_valid (bus.dw_valid),
      .in_word  (bus.dw_in),
      .finish   (finish),
      .in_ready (in_ready),
      .a_word   (a_word),
      .a_full   (a_full),
      .a_load   (a_load)
   );

   assign is_first = a_full & (beat_idx_q == '0);
   assign is_last  = a_full & (beat_idx_q == BEAT_W'(NB - 1));
   assign xfer     = a_full & bus.sink_ready;
   assign finish   = xfer & is_last;

   assign bus.dw_ready       = in_ready;
   assign bus.data_valid_out = a_full;
   assign bus.first_data_out = is_first;
   assign bus.last_data_out  = is_last;
   assign bus.data_out       = a_full ? beat_data : '0;
   assign word_cnt           = word_cnt_q;

   // Zero-extend the active word and select the current beat.
   always_comb begin
      a_ext          = '0;
      a_ext[K-1:0]   = a_word;
      beat_data      = '0;
      for (int b = 0; b < NB; b++) begin
         if (beat_idx_q == BEAT_W'(b)) begin
            beat_data = a_ext[b*N_OUT +: N_OUT];
         end
      end
   end

   // Advance the beat on transfer, restart on a new word or finish.
   always_comb begin
      beat_idx_d = beat_idx_q;
      word_cnt_d = word_cnt_q;
      if (a_load || finish) begin
         beat_idx_d = '0;
      end else if (xfer) begin
         beat_idx_d = beat_idx_q + BEAT_W'(1);
      end
      if (finish) begin
         word_cnt_d = word_cnt_q + CNT_W'(1);
      end
   end

   // Beat position and completed-word count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RESET_VAL) begin
         beat_idx_q <= '0;
         word_cnt_q <= '0;
      end else begin
         beat_idx_q <= beat_idx_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_dw_out_serializer.sv
// Directed bench for dw_out_serializer: default K=32 instance plus
// a K=30 instance for last-beat padding.
module tb_dw_out_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cnt1;
   logic [15:0] cnt2;
   int          tests = 0;
   int          fails = 0;

   dw_out_if #(.K(32), .N_OUT(4)) if1 ();
   dw_out_if #(.K(30), .N_OUT(4)) if2 ();

   dw_out_serializer #(.N_V(44), .N_C(12), .N_OUT(4), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .bus(if1.slave), .word_cnt(cnt1));

   dw_out_serializer #(.N_V(42), .N_C(12), .N_OUT(4), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .bus(if2.slave), .word_cnt(cnt2));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      rst = 1'b1;
      if1.dw_valid = 1'b0; if1.dw_in = '0; if1.sink_ready = 1'b0;
      if2.dw_valid = 1'b0; if2.dw_in = '0; if2.sink_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if1.dw_valid = 1'b0; if1.dw_in = '0; if1.sink_ready = 1'b0;
      if2.dw_valid = 1'b0; if2.dw_in = '0; if2.sink_ready = 1'b0;
      @(negedge clk);
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", if1.data_valid_out); end
      tests++; if (if1.data_out !== 4'h0) begin fails++; $display("FAIL rst_data: got %h want 0", if1.data_out); end
      tests++; if (if1.first_data_out !== 1'b0 || if1.last_data_out !== 1'b0) begin fails++; $display("FAIL rst_first_last: got %b%b want 00", if1.first_data_out, if1.last_data_out); end
      tests++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", cnt1); end
      tests++; if (if1.dw_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", if1.dw_ready); end
      rst = 1'b0;
      @(negedge clk);
      tests++; if (if1.dw_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_release: got %b want 1", if1.dw_ready); end
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid_release: got %b want 0", if1.data_valid_out); end
   endtask

   task automatic test_single();
      logic [31:0] w;
      w = 32'h8765_4321;
      do_reset();
      if1.sink_ready = 1'b1;
      if1.dw_in = w;
      if1.dw_valid = 1'b1;
      @(negedge clk);
      if1.dw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tests++; if (if1.data_valid_out !== 1'b1) begin fails++; $display("FAIL single_valid beat %0d: got %b want 1", i, if1.data_valid_out); end
         tests++; if (if1.data_out !== 4'(i + 1)) begin fails++; $display("FAIL single_data beat %0d: got %h want %h", i, if1.data_out, 4'(i + 1)); end
         tests++; if (if1.first_data_out !== (i == 0)) begin fails++; $display("FAIL single_first beat %0d: got %b want %b", i, if1.first_data_out, (i == 0)); end
         tests++; if (if1.last_data_out !== (i == 7)) begin fails++; $display("FAIL single_last beat %0d: got %b want %b", i, if1.last_data_out, (i == 7)); end
         tests++; if (if1.dw_ready !== 1'b1) begin fails++; $display("FAIL single_ready beat %0d: got %b want 1", i, if1.dw_ready); end
         @(negedge clk);
      end
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL single_idle: got %b want 0", if1.data_valid_out); end
      tests++; if (cnt1 !== 16'd1) begin fails++; $display("FAIL single_cnt: got %0d want 1", cnt1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1;
      logic [31:0] w2;
      logic [3:0]  exp;
      logic        exp_rdy;
      w1 = 32'hFFFF_0000;
      w2 = 32'h0000_FFFF;
      do_reset();
      if1.sink_ready = 1'b1;
      if1.dw_in = w1;
      if1.dw_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         if (i == 0) begin
            if1.dw_in = w2;
            if1.dw_valid = 1'b1;
         end else begin
            if1.dw_valid = 1'b0;
         end
         exp = (i < 8) ? 4'(w1 >> (4 * i)) : 4'(w2 >> (4 * (i - 8)));
         exp_rdy = !(i >= 1 && i <= 7);
         tests++; if (if1.data_valid_out !== 1'b1) begin fails++; $display("FAIL b2b_valid beat %0d: got %b want 1", i, if1.data_valid_out); end
         tests++; if (if1.data_out !== exp) begin fails++; $display("FAIL b2b_data beat %0d: got %h want %h", i, if1.data_out, exp); end
         tests++; if (if1.first_data_out !== (i % 8 == 0)) begin fails++; $display("FAIL b2b_first beat %0d: got %b want %b", i, if1.first_data_out, (i % 8 == 0)); end
         tests++; if (if1.dw_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready beat %0d: got %b want %b", i, if1.dw_ready, exp_rdy); end
         @(negedge clk);
      end
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b want 0", if1.data_valid_out); end
      tests++; if (cnt1 !== 16'd2) begin fails++; $display("FAIL b2b_cnt: got %0d want 2", cnt1); end
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      logic [3:0]  exp;
      int          beats;
      int          stalls;
      int          cyc;
      w = 32'hA5A5_A5A5;
      do_reset();
      if1.sink_ready = 1'b1;
      if1.dw_in = w;
      if1.dw_valid = 1'b1;
      @(negedge clk);
      if1.dw_valid = 1'b0;
      beats = 0;
      stalls = 0;
      cyc = 0;
      while (beats < 8 && cyc < 40) begin
         exp = 4'(w >> (4 * beats));
         tests++; if (if1.data_valid_out !== 1'b1) begin fails++; $display("FAIL bp_valid cyc %0d: got %b want 1", cyc, if1.data_valid_out); end
         tests++; if (if1.data_out !== exp) begin fails++; $display("FAIL bp_data cyc %0d: got %h want %h", cyc, if1.data_out, exp); end
         tests++; if (if1.first_data_out !== (beats == 0)) begin fails++; $display("FAIL bp_first cyc %0d: got %b want %b", cyc, if1.first_data_out, (beats == 0)); end
         tests++; if (if1.last_data_out !== (beats == 7)) begin fails++; $display("FAIL bp_last cyc %0d: got %b want %b", cyc, if1.last_data_out, (beats == 7)); end
         if (beats == 2 && stalls < 5) begin
            if1.sink_ready = 1'b0;
            stalls++;
         end else begin
            if1.sink_ready = 1'b1;
            beats++;
         end
         cyc++;
         @(negedge clk);
      end
      tests++; if (beats != 8) begin fails++; $display("FAIL bp_timeout: got %0d beats want 8", beats); end
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL bp_idle: got %b want 0", if1.data_valid_out); end
      tests++; if (cnt1 !== 16'd1) begin fails++; $display("FAIL bp_cnt: got %0d want 1", cnt1); end
   endtask

   task automatic test_pending_full();
      logic [31:0] w [3];
      logic [31:0] cur;
      logic [3:0]  exp;
      int          nxt;
      int          got;
      int          cyc;
      logic        pend;
      w[0] = 32'h7654_3210;
      w[1] = 32'hFEDC_BA98;
      w[2] = 32'h1357_9BDF;
      do_reset();
      if1.sink_ready = 1'b0;
      if1.dw_in = w[0];
      if1.dw_valid = 1'b1;
      @(negedge clk);
      tests++; if (if1.dw_ready !== 1'b1) begin fails++; $display("FAIL pf_ready_a: got %b want 1", if1.dw_ready); end
      if1.dw_in = w[1];
      @(negedge clk);
      tests++; if (if1.dw_ready !== 1'b0) begin fails++; $display("FAIL pf_ready_p: got %b want 0", if1.dw_ready); end
      if1.dw_in = w[2];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++; if (if1.dw_ready !== 1'b0) begin fails++; $display("FAIL pf_stall_ready %0d: got %b want 0", i, if1.dw_ready); end
         tests++; if (if1.data_out !== 4'h0 || if1.data_valid_out !== 1'b1) begin fails++; $display("FAIL pf_stall_data %0d: got %h/%b want 0/1", i, if1.data_out, if1.data_valid_out); end
      end
      if1.sink_ready = 1'b1;
      nxt = 2;
      got = 0;
      cyc = 0;
      pend = 1'b0;
      while (got < 24 && cyc < 100) begin
         if (pend) begin
            nxt++;
            if (nxt < 3) if1.dw_in = w[nxt];
            else if1.dw_valid = 1'b0;
         end
         pend = if1.dw_valid && if1.dw_ready;
         if (if1.data_valid_out) begin
            cur = w[got / 8];
            exp = 4'(cur >> (4 * (got % 8)));
            tests++; if (if1.data_out !== exp) begin fails++; $display("FAIL pf_data beat %0d: got %h want %h", got, if1.data_out, exp); end
            got++;
         end
         cyc++;
         @(negedge clk);
      end
      tests++; if (got != 24) begin fails++; $display("FAIL pf_beats: got %0d want 24", got); end
      tests++; if (nxt != 3) begin fails++; $display("FAIL pf_third_accept: got %0d want 3", nxt); end
      tests++; if (cnt1 !== 16'd3) begin fails++; $display("FAIL pf_cnt: got %0d want 3", cnt1); end
   endtask

   task automatic test_padding();
      logic [3:0] exp;
      do_reset();
      if2.sink_ready = 1'b1;
      if2.dw_in = 30'h3FFF_FFFF;
      if2.dw_valid = 1'b1;
      @(negedge clk);
      if2.dw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp = (i == 7) ? 4'h3 : 4'hF;
         tests++; if (if2.data_valid_out !== 1'b1) begin fails++; $display("FAIL pad_valid beat %0d: got %b want 1", i, if2.data_valid_out); end
         tests++; if (if2.data_out !== exp) begin fails++; $display("FAIL pad_data beat %0d: got %h want %h", i, if2.data_out, exp); end
         tests++; if (if2.last_data_out !== (i == 7)) begin fails++; $display("FAIL pad_last beat %0d: got %b want %b", i, if2.last_data_out, (i == 7)); end
         @(negedge clk);
      end
      tests++; if (cnt2 !== 16'd1) begin fails++; $display("FAIL pad_cnt: got %0d want 1", cnt2); end
   endtask

   task automatic test_async_reset();
      do_reset();
      if1.sink_ready = 1'b1;
      if1.dw_in = 32'hCAFE_1234;
      if1.dw_valid = 1'b1;
      @(negedge clk);
      if1.dw_valid = 1'b0;
      repeat (8) @(negedge clk);
      tests++; if (cnt1 !== 16'd1) begin fails++; $display("FAIL ar_pre_cnt: got %0d want 1", cnt1); end
      if1.dw_valid = 1'b1;
      @(negedge clk);
      if1.dw_valid = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (if1.data_out !== 4'h1) begin fails++; $display("FAIL ar_beat4: got %h want 1", if1.data_out); end
      #2;
      rst = 1'b1;
      #1;
      tests++; if (if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b want 0", if1.data_valid_out); end
      tests++; if (if1.data_out !== 4'h0) begin fails++; $display("FAIL ar_data: got %h want 0", if1.data_out); end
      tests++; if (if1.first_data_out !== 1'b0 || if1.last_data_out !== 1'b0) begin fails++; $display("FAIL ar_first_last: got %b%b want 00", if1.first_data_out, if1.last_data_out); end
      tests++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL ar_cnt: got %0d want 0", cnt1); end
      tests++; if (if1.dw_ready !== 1'b0) begin fails++; $display("FAIL ar_ready: got %b want 0", if1.dw_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++; if (if1.dw_ready !== 1'b1 || if1.data_valid_out !== 1'b0) begin fails++; $display("FAIL ar_release: got rdy %b vld %b want 1 0", if1.dw_ready, if1.data_valid_out); end
      if1.dw_in = 32'h0000_00B7;
      if1.dw_valid = 1'b1;
      @(negedge clk);
      if1.dw_valid = 1'b0;
      tests++; if (if1.first_data_out !== 1'b1 || if1.data_out !== 4'h7) begin fails++; $display("FAIL ar_new_beat0: got first %b data %h want 1 7", if1.first_data_out, if1.data_out); end
      @(negedge clk);
      tests++; if (if1.first_data_out !== 1'b0 || if1.data_out !== 4'hB) begin fails++; $display("FAIL ar_new_beat1: got first %b data %h want 0 b", if1.first_data_out, if1.data_out); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_pending_full();
      test_padding();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
